// File: rtl/alu_result_fifo_if.sv
// rtl/alu_result_fifo_if.sv - Result word handshake bundle between ALU core, result FIFO and readout
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface alu_result_fifo_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - FWFT result FIFO with saturating error count and sticky overflow
// Optional almost_full output enabled by defining ALU_FIFO_ALMOST_FULL_EN.
module alu_result_fifo #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int ERRCNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_result_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [ERRCNT_W-1:0]     err_count,
  output logic                    overflow,
  input  logic                    clr_stats
`ifdef ALU_FIFO_ALMOST_FULL_EN
  ,
  output logic                    almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]    LVL_FULL = LVL_W'(DEPTH);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = '1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic err_hit;

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign push    = bus.in_valid && !full;
  assign pop     = bus.out_ready && !empty;
  assign drop    = bus.in_valid && full;
  assign err_hit = push && bus.in_data[3];

  // Outputs depend only on registered state, never on this cycle's inputs.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign level         = count;

`ifdef ALU_FIFO_ALMOST_FULL_EN
  localparam logic [LVL_W-1:0] LVL_AF = LVL_W'(DEPTH - 2);
  assign almost_full = (count >= LVL_AF);
`endif

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // clr_stats wins over a same-edge increment or overflow set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (clr_stats) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (err_hit && (err_count != ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - Directed bench for alu_result_fifo with queue-based reference model
module tb_alu_result_fifo;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic       clr_stats;
  logic [3:0] level;
  logic [3:0] err_count;
  logic       overflow;
`ifdef ALU_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  alu_result_fifo_if #(.WIDTH(8)) bus ();

  alu_result_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8),
    .ERRCNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .level(level),
    .err_count(err_count),
    .overflow(overflow),
    .clr_stats(clr_stats)
`ifdef ALU_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus plain counters.
  logic [7:0] mq[$];
  int         m_err = 0;
  bit         m_ovf = 0;
  bit         live = 0;
  bit         m_push;
  bit         m_pop;
  int         m_sz;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_err = 0;
      m_ovf = 0;
      live  = 1;
    end else if (live) begin
      m_sz   = mq.size();
      m_push = bus.in_valid && (m_sz < DEPTH);
      m_pop  = bus.out_ready && (m_sz > 0);
      if (bus.in_valid && m_sz == DEPTH) m_ovf = 1;
      if (m_push && bus.in_data[3] && m_err < 15) m_err = m_err + 1;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(bus.in_data);
      if (clr_stats) begin
        m_err = 0;
        m_ovf = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      check("out_data", 32'(bus.out_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      check("level", 32'(level), 32'(mq.size()));
      check("err_count", 32'(err_count), 32'(m_err));
      check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ALU_FIFO_ALMOST_FULL_EN
      check("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - 2));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    clr_stats     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Three back-to-back pushes, then drain in order.
    bus.in_valid = 1'b1;
    bus.in_data = 8'h15; step();
    bus.in_data = 8'h2A; step();
    bus.in_data = 8'h3F; step();
    bus.in_valid = 1'b0;
    check("t2_level3", 32'(level), 32'd3);
    bus.out_ready = 1'b1;
    check("t2_head0", 32'(bus.out_data), 32'h15);
    step();
    check("t2_head1", 32'(bus.out_data), 32'h2A);
    step();
    check("t2_head2", 32'(bus.out_data), 32'h3F);
    step();
    check("t2_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Fill, then push while full with a same-cycle pop: push is dropped.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(8'h80 + i);
      step();
    end
    check("t3_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data = 8'h99;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_level7", 32'(level), 32'd7);
    check("t3_head", 32'(bus.out_data), 32'h81);
    repeat (7) step();
    bus.out_ready = 1'b0;
    check("t3_drained", 32'(level), 32'd0);

    // Fill/drain rounds to exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bus.in_data = 8'(r * 16 + i * 3 + 1);
        step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) step();
      bus.out_ready = 1'b0;
      check("t4_level0", 32'(level), 32'd0);
    end

    // Error counter saturation and clear-over-increment priority.
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    check("t5_cleared_ovf", 32'(overflow), 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = {i[3:0], 4'h8};
      step();
    end
    bus.in_valid = 1'b0;
    check("t5_err_sat", 32'(err_count), 32'd15);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h0C;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_err_clr", 32'(err_count), 32'd0);
    repeat (2) step();
    bus.out_ready = 1'b0;
    check("t5_level0", 32'(level), 32'd0);

    // Almost-full threshold, then reset with data stored.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'(8'hC0 + i);
      step();
    end
    bus.in_valid = 1'b0;
    check("t6_level6", 32'(level), 32'd6);
`ifdef ALU_FIFO_ALMOST_FULL_EN
    check("t6_af_at6", 32'(almost_full), 32'd1);
`endif
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("t6_level5", 32'(level), 32'd5);
`ifdef ALU_FIFO_ALMOST_FULL_EN
    check("t6_af_at5", 32'(almost_full), 32'd0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_level", 32'(level), 32'd0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_data", 32'(bus.out_data), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
